// File: rtl/task_answer_arbiter.sv
// rtl/task_answer_arbiter.sv - round-robin arbiter sharing the task-manager answer channel
module task_answer_arbiter #(
    parameter int NUM_TASKS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SIZE_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ID_WIDTH       = $clog2(NUM_TASKS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_TASKS-1:0]             i_req_ready,
    input  logic [NUM_TASKS*DATA_WIDTH-1:0]  i_req_data,
    input  logic [NUM_TASKS-1:0]             i_req_last,
    input  logic [NUM_TASKS*SIZE_WIDTH-1:0]  i_req_size,
    output logic [NUM_TASKS-1:0]             o_req_rd,
    input  logic                             i_mgr_ready,
    output logic                             o_ans_valid,
    output logic [DATA_WIDTH-1:0]            o_ans_data,
    output logic                             o_ans_last,
    output logic [SIZE_WIDTH-1:0]            o_ans_size,
    output logic [ID_WIDTH-1:0]              o_ans_task_id,
    output logic                             o_busy,
    output logic                             o_timeout
);

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_STREAM,
        S_RELEASE
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [SIZE_WIDTH-1:0] r_beat_cnt;
    logic [WD_WIDTH-1:0]   r_wd_cnt;

    logic                  arb_found;
    logic [ID_WIDTH-1:0]   arb_sel;
    logic [SIZE_WIDTH-1:0] arb_size;
    int                    arb_idx;

    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_last;
    logic                  timeout_hit;
    logic                  beat_valid;
    logic                  xfer;

    // round-robin pick: first requester scanning upward from the previous winner
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NUM_TASKS; i++) begin
            arb_idx = (int'(r_last_grant) + i) % NUM_TASKS;
            if (!arb_found && i_req_ready[ID_WIDTH'(arb_idx)]) begin
                arb_found = 1'b1;
                arb_sel   = ID_WIDTH'(arb_idx);
            end
        end
    end

    // packet size offered by the arbitration winner
    always_comb begin
        arb_size = '0;
        for (int k = 0; k < NUM_TASKS; k++) begin
            if (arb_sel == ID_WIDTH'(k)) begin
                arb_size = i_req_size[k*SIZE_WIDTH +: SIZE_WIDTH];
            end
        end
    end

    // a beat may move only in STREAM, and never on the watchdog abort cycle
    always_comb begin
        timeout_hit = (state == S_STREAM) && (r_wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES));
        beat_valid  = (state == S_STREAM) && !timeout_hit;
        xfer        = beat_valid && i_mgr_ready;
        o_ans_valid = beat_valid;
        o_ans_data  = beat_valid ? g_data : '0;
        o_ans_last  = beat_valid && g_last;
        o_timeout   = timeout_hit;
    end

    // route the granted lane and send manager ready back to the granted task only
    always_comb begin
        g_data   = '0;
        g_last   = 1'b0;
        o_req_rd = '0;
        for (int k = 0; k < NUM_TASKS; k++) begin
            if (o_ans_task_id == ID_WIDTH'(k)) begin
                g_data      = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
                g_last      = i_req_last[k];
                o_req_rd[k] = xfer;
            end
        end
    end

    // grant sequencing: lock the winner for a whole packet, watchdog aborts a stuck one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            r_last_grant  <= ID_WIDTH'(NUM_TASKS - 1);
            o_ans_task_id <= '0;
            o_ans_size    <= '0;
            o_busy        <= 1'b0;
            r_beat_cnt    <= '0;
            r_wd_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        state         <= S_GRANT;
                        o_ans_task_id <= arb_sel;
                        r_last_grant  <= arb_sel;
                        o_ans_size    <= arb_size;
                        o_busy        <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_wd_cnt      <= '0;
                    end
                end
                S_GRANT: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (xfer && (r_beat_cnt != '1)) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (timeout_hit || (xfer && g_last)) begin
                        state      <= S_RELEASE;
                        o_busy     <= 1'b0;
                        o_ans_size <= '0;
                        r_wd_cnt   <= '0;
                    end
                end
                S_RELEASE: begin
                    state      <= S_IDLE;
                    r_beat_cnt <= '0;
                    r_wd_cnt   <= '0;
                    o_ans_size <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_answer_arbiter.sv
// tb/tb_task_answer_arbiter.sv - vectors, corner sequences and randomized model check for task_answer_arbiter
module tb_task_answer_arbiter;

    localparam int NT = 4;
    localparam int DW = 8;
    localparam int SW = 12;
    localparam int TO = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NT-1:0]  req_ready = '0;
    logic [NT*DW-1:0] req_data = '0;
    logic [NT-1:0]  req_last = '0;
    logic [NT*SW-1:0] req_size = '0;
    logic [NT-1:0]  req_rd;
    logic           mgr_ready = 1'b0;
    logic           ans_valid;
    logic [DW-1:0]  ans_data;
    logic           ans_last;
    logic [SW-1:0]  ans_size;
    logic [IW-1:0]  ans_id;
    logic           busy;
    logic           timeout;
    logic [29:0]    obs;

    int errors = 0;
    int checks = 0;

    task_answer_arbiter #(
        .NUM_TASKS(NT), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(TO), .ID_WIDTH(IW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_ready(req_ready), .i_req_data(req_data), .i_req_last(req_last), .i_req_size(req_size),
        .o_req_rd(req_rd), .i_mgr_ready(mgr_ready),
        .o_ans_valid(ans_valid), .o_ans_data(ans_data), .o_ans_last(ans_last),
        .o_ans_size(ans_size), .o_ans_task_id(ans_id), .o_busy(busy), .o_timeout(timeout)
    );

    assign obs = {busy, ans_valid, timeout, ans_last, req_rd, ans_data, ans_size, ans_id};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [29:0] mk(logic b, logic v, logic t, logic l, logic [3:0] rd,
                                       logic [7:0] d, logic [11:0] s, logic [1:0] id);
        return {b, v, t, l, rd, d, s, id};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = '0;
        req_last = '0;
        mgr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", obs, 30'd0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (ans_valid) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] dbus;
        logic [3:0]  lastb;
        logic        mgr;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs [14];

    int          f_id [8];
    int          f_cyc [8];
    int          nb, t_g, t_to, n_to, n_v, id_after;
    bit          ok, prev_busy;
    int          pend [NT];
    int          plen [NT];
    int          ppos [NT];
    logic [7:0]  pbytes [NT][4];
    int          m_pos, m_id, m_lastg, w, idx;
    bit          m_rel;
    logic        e_valid, e_to, e_xfer, e_last, e_busy;
    logic [7:0]  e_data;
    logic [3:0]  e_rd;
    logic [11:0] e_size;

    initial begin
        // cycle-by-cycle vectors: single request on task 0, then backpressured packet on task 2
        vecs[0]  = '{4'b0000, 32'hF3F2F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd0)};
        vecs[1]  = '{4'b0001, 32'hF3F2F1A5, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd0)};
        vecs[2]  = '{4'b0001, 32'hF3F2F1A5, 4'b0000, 1'b1, mk(1,0,0,0,4'b0000,8'h00,12'd2,2'd0)};
        vecs[3]  = '{4'b0001, 32'hF3F2F1A5, 4'b0000, 1'b1, mk(1,1,0,0,4'b0001,8'hA5,12'd2,2'd0)};
        vecs[4]  = '{4'b0001, 32'hF3F2F15A, 4'b0001, 1'b1, mk(1,1,0,1,4'b0001,8'h5A,12'd2,2'd0)};
        vecs[5]  = '{4'b0000, 32'hF3F2F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd0)};
        vecs[6]  = '{4'b0000, 32'hF3F2F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd0)};
        vecs[7]  = '{4'b0100, 32'hF311F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd0)};
        vecs[8]  = '{4'b0100, 32'hF311F1F0, 4'b0000, 1'b1, mk(1,0,0,0,4'b0000,8'h00,12'd2,2'd2)};
        vecs[9]  = '{4'b0100, 32'hF311F1F0, 4'b0000, 1'b1, mk(1,1,0,0,4'b0100,8'h11,12'd2,2'd2)};
        vecs[10] = '{4'b0100, 32'hF322F1F0, 4'b0100, 1'b0, mk(1,1,0,1,4'b0000,8'h22,12'd2,2'd2)};
        vecs[11] = '{4'b0100, 32'hF322F1F0, 4'b0100, 1'b1, mk(1,1,0,1,4'b0100,8'h22,12'd2,2'd2)};
        vecs[12] = '{4'b0000, 32'hF3F2F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd2)};
        vecs[13] = '{4'b0000, 32'hF3F2F1F0, 4'b0000, 1'b1, mk(0,0,0,0,4'b0000,8'h00,12'd0,2'd2)};

        do_reset();
        req_size = {12'd1, 12'd2, 12'd1, 12'd2};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_ready = vecs[i].req;
            req_data  = vecs[i].dbus;
            req_last  = vecs[i].lastb;
            mgr_ready = vecs[i].mgr;
            #1;
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // fairness: all tasks request continuously with one-beat packets
        do_reset();
        for (int i = 0; i < 8; i++) begin
            f_id[i] = -1;
            f_cyc[i] = -100 * (i + 1);
        end
        nb = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            req_ready = 4'b1111;
            req_last  = 4'b1111;
            req_data  = 32'h33221100;
            mgr_ready = 1'b1;
            #1;
            if (ans_valid && nb < 8) begin
                f_id[nb] = int'(ans_id);
                f_cyc[nb] = c;
                check("fair_data", ans_data, 8'(int'(ans_id) * 17));
                nb++;
            end
        end
        check("fair_id0", f_id[0], 0);
        check("fair_id1", f_id[1], 1);
        check("fair_id2", f_id[2], 2);
        check("fair_id3", f_id[3], 3);
        check("fair_id4", f_id[4], 0);
        for (int i = 0; i < 4; i++) check("fair_spacing", f_cyc[i+1] - f_cyc[i], 4);

        // watchdog: task 1 never signals last
        do_reset();
        t_g = -1; t_to = -1; n_to = 0; n_v = 0; id_after = -1; prev_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_ready = (n_to > 0) ? 4'b1111 : 4'b0010;
            req_last  = 4'b0000;
            mgr_ready = 1'b1;
            #1;
            if (busy && t_g < 0) t_g = c;
            if (ans_valid && n_to == 0) n_v++;
            if (timeout) begin
                n_to++;
                t_to = c;
                check("wd_valid_low", {ans_valid, req_rd}, 5'b0);
            end
            if (n_to > 0 && busy && !prev_busy) id_after = int'(ans_id);
            prev_busy = busy;
        end
        check("wd_pulse_count", n_to, 1);
        check("wd_pulse_time", t_to, t_g + 1 + TO);
        check("wd_beats", n_v, TO);
        check("wd_next_grant", id_after, 2);

        // reset in the middle of a packet on task 2
        do_reset();
        @(negedge clk);
        req_ready = 4'b0100;
        mgr_ready = 1'b1;
        wait_valid(ok);
        check("rst_mid_reach", ok, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        req_ready = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_outputs", obs, 30'd0);
        @(negedge clk);
        #1;
        check("rst_mid_regrant", {busy, ans_id}, {1'b1, 2'd0});

        // late request from task 1 while task 3 streams
        do_reset();
        @(negedge clk);
        req_ready = 4'b1000;
        mgr_ready = 1'b1;
        wait_valid(ok);
        check("late_reach", ok, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_ready = 4'b1010;
            #1;
            check("late_rd", {req_rd, ans_id}, {4'b1000, 2'd3});
        end
        @(negedge clk);
        req_last = 4'b1000;
        #1;
        check("late_last", {req_rd, ans_last}, {4'b1000, 1'b1});
        @(negedge clk);
        req_last = 4'b0000;
        #1;
        check("late_release", {busy, req_rd}, 5'b0);
        @(negedge clk);
        #1;
        check("late_idle", {busy, req_rd}, 5'b0);
        @(negedge clk);
        #1;
        check("late_grant", {busy, ans_id}, {1'b1, 2'd1});

        // randomized traffic against a packet-level reference model
        do_reset();
        m_pos = -1; m_rel = 1'b0; m_id = 0; m_lastg = NT - 1;
        for (int k = 0; k < NT; k++) begin
            pend[k] = 0; plen[k] = 1; ppos[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NT; k++) begin
                if (pend[k] == 0 && $urandom_range(3) == 0) begin
                    pend[k] = 1;
                    plen[k] = $urandom_range(4, 1);
                    ppos[k] = 0;
                    for (int b = 0; b < 4; b++) pbytes[k][b] = 8'($urandom);
                end
            end
            @(negedge clk);
            for (int k = 0; k < NT; k++) begin
                req_ready[k] = (pend[k] != 0) &&
                               !(k == m_id && m_pos >= 1 && $urandom_range(7) == 0);
                req_data[k*DW +: DW] = (pend[k] != 0) ? pbytes[k][ppos[k]] : 8'($urandom);
                req_last[k] = (pend[k] != 0) && (ppos[k] == plen[k] - 1);
                req_size[k*SW +: SW] = (pend[k] != 0) ? 12'(plen[k]) : 12'($urandom);
            end
            mgr_ready = ($urandom_range(3) >= ((cyc < 1500) ? 1 : 2));
            #1;
            idx     = m_pos - 1;
            e_busy  = (m_pos >= 0);
            e_to    = (m_pos >= 1) && (idx == TO);
            e_valid = (m_pos >= 1) && (idx < TO);
            e_xfer  = e_valid && mgr_ready;
            e_last  = e_valid && (ppos[m_id] == plen[m_id] - 1);
            e_data  = e_valid ? pbytes[m_id][ppos[m_id]] : 8'h00;
            e_rd    = e_xfer ? 4'(1 << m_id) : 4'b0000;
            e_size  = e_busy ? 12'(plen[m_id]) : 12'd0;
            check($sformatf("rand_cyc%0d", cyc), obs,
                  mk(e_busy, e_valid, e_to, e_last, e_rd, e_data, e_size, 2'(m_id)));
            if (m_rel) begin
                m_rel = 1'b0;
            end else if (m_pos < 0) begin
                w = -1;
                for (int i = 1; i <= NT; i++) begin
                    if (w < 0 && req_ready[(m_lastg + i) % NT]) w = (m_lastg + i) % NT;
                end
                if (w >= 0) begin
                    m_id = w;
                    m_lastg = w;
                    m_pos = 0;
                end
            end else if (e_to) begin
                pend[m_id] = 0;
                m_pos = -1;
                m_rel = 1'b1;
            end else if (e_xfer && e_last) begin
                pend[m_id] = 0;
                m_pos = -1;
                m_rel = 1'b1;
            end else begin
                if (e_xfer) ppos[m_id]++;
                m_pos++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/task_answer_arbiter.md
Name: task_answer_arbiter

Overview:
- Shares the single task-manager answer channel between NUM_TASKS task output blocks.
- Each task output block raises an answer-ready flag and offers a byte stream with a last flag and a packet size.
- Arbitration is round-robin. The grant is locked for a whole packet, and the winner's data, size and last flag are multiplexed onto the manager interface.
- Manager ready is routed back only to the granted task. A watchdog releases the channel if a packet never terminates.

Parameters:
- NUM_TASKS, 4, number of requesting task output blocks (2..16).
- DATA_WIDTH, 8, answer data beat width.
- SIZE_WIDTH, 12, packet size field width in bytes.
- TIMEOUT_CYCLES, 256, maximum cycles in STREAM before the packet is aborted.
- ID_WIDTH, $clog2(NUM_TASKS), width of the task index.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_ready  in  NUM_TASKS  per-task answer ready; bit k is the request from task k.
- i_req_data  in  NUM_TASKS*DATA_WIDTH  per-task data; task k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last  in  NUM_TASKS  per-task last-beat flag.
- i_req_size  in  NUM_TASKS*SIZE_WIDTH  per-task packet size in bytes.
- o_req_rd  out  NUM_TASKS  per-task read strobe (the manager ready, demultiplexed).
- i_mgr_ready  in  1  manager accepts the current beat.
- o_ans_valid  out  1  beat valid toward the manager.
- o_ans_data  out  DATA_WIDTH  muxed data.
- o_ans_last  out  1  last beat of the packet.
- o_ans_size  out  SIZE_WIDTH  size of the granted packet.
- o_ans_task_id  out  ID_WIDTH  index of the granted task.
- o_busy  out  1  channel is granted.
- o_timeout  out  1  one-cycle pulse when a packet is aborted by the watchdog.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE.
  - r_last_grant is set to NUM_TASKS-1, so task 0 has first priority.
  - All outputs are 0 (o_req_rd, o_ans_*, o_busy, o_timeout).
  - The beat counter and watchdog counter are cleared.
  - Reset mid-packet aborts immediately. No o_timeout pulse is raised and no last beat is emitted.
- States: IDLE, GRANT, STREAM, RELEASE.
- IDLE:
  - If any i_req_ready bit is set, select the first set index scanning upward from r_last_grant+1, wrapping modulo NUM_TASKS.
  - Register the selection g into o_ans_task_id and r_last_grant.
  - Register i_req_size[g] into o_ans_size.
  - Set o_busy=1 and go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT: lasts one cycle; o_ans_valid=0; go to STREAM. This cycle gives the requester time to settle its FIFO output.
- STREAM (combinational outputs):
  - o_ans_valid=1.
  - o_ans_data=i_req_data[g].
  - o_ans_last=i_req_last[g].
  - o_req_rd[g]=i_mgr_ready; all other o_req_rd bits are 0.
- Beat transfer:
  - A beat transfers on a cycle with o_ans_valid && i_mgr_ready.
  - The beat counter increments per transfer and saturates at 2^SIZE_WIDTH-1. It is informational only.
- Packet end:
  - A transfer while i_req_last[g]=1 ends the packet; go to RELEASE.
  - A last flag without i_mgr_ready does not end the packet.
- Ready drop: if i_req_ready[g] falls during STREAM it is ignored. The grant is held until last or timeout.
- Watchdog:
  - Counts every cycle spent in STREAM. It is not cleared by individual beats.
  - When the count reaches TIMEOUT_CYCLES without a last transfer: pulse o_timeout for 1 cycle and go to RELEASE.
  - No beat is transferred on the timeout cycle (o_ans_valid forced 0, o_req_rd forced 0 that cycle).
- RELEASE:
  - Lasts one cycle; o_ans_valid=0 and o_busy=0.
  - Clears the counters and o_ans_size; o_ans_task_id holds its value.
  - Go to IDLE.
  - No arbitration happens in RELEASE, so the minimum gap between packets is 3 cycles of overhead (RELEASE, IDLE, GRANT).
- Fairness: the task just served has lowest priority in the next arbitration.
- Simultaneous requests: only the round-robin winner is granted. The other requests stay pending, and nothing is dropped.
- Request arriving in GRANT, STREAM or RELEASE: considered at the next IDLE.
- Latency: i_req_ready set in IDLE at cycle t gives the first possible beat transfer at t+2.

Test Plan:
- Single request: i_req_ready=0001, size 2, two beats 0xA5, 0x5A, last on the 2nd beat, i_mgr_ready=1.
  - o_busy=1 at t+1; o_ans_valid at t+2.
  - Data 0xA5, 0x5A with o_ans_last on the 2nd beat; o_req_rd=0001 for 2 cycles.
  - o_ans_size=2 and o_ans_task_id=0 during the packet; back to IDLE at t+4.
- Fairness: i_req_ready=1111 held continuously, 1-beat packets.
  - Grant order is 0,1,2,3,0.
  - o_ans_task_id sequence is 0,1,2,3,0, with a 3-cycle gap between packets.
- Backpressure: i_mgr_ready toggling 1,0,1 during a 2-beat packet.
  - o_req_rd[g] mirrors i_mgr_ready; data is held while not ready.
  - Exactly 2 transfers; last accepted only with ready=1.
- Watchdog: TIMEOUT_CYCLES=8, granted task never asserts last.
  - o_timeout=1 for exactly one cycle, 8 cycles after STREAM entry.
  - o_ans_valid=0 that cycle; next arbitration starts from task g+1.
- Reset mid-stream: assert i_rst while in STREAM on task 2.
  - All outputs 0 the next cycle; no o_timeout pulse.
  - The following request set 0100 plus 0001 grants task 0 first.
- Late request: task 1 raises i_req_ready while task 3 is streaming.
  - Task 1 is not granted until after RELEASE; no overlap on o_req_rd.
